// File: rtl/hex_scroll_pkg.sv
// Shared types for the seven-segment scroller: glyph codes, FSM states and
// the built-in 16-entry message.
package hex_scroll_pkg;

    typedef enum logic [4:0] {
        G_X0, G_X1, G_X2, G_X3, G_X4, G_X5, G_X6, G_X7,
        G_X8, G_X9, G_XA, G_XB, G_XC, G_XD, G_XE, G_XF,
        G_H, G_L, G_P, G_A, G_C, G_E, G_O, G_B, G_DASH, G_BLANK
    } glyph_t;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    localparam int MSG_LEN = 16;

    // "HELLO CA LAB" padded with blanks so the scroll has a visible gap
    localparam glyph_t MSG_DEFAULT [MSG_LEN] = '{
        G_H, G_E, G_L, G_L, G_O, G_BLANK, G_C, G_A,
        G_BLANK, G_L, G_A, G_B, G_BLANK, G_BLANK, G_BLANK, G_BLANK
    };

endpackage

// File: rtl/seg7_glyph_enc.sv
// Glyph to active-low segment pattern, bit order g..a. DP is not handled here.
module seg7_glyph_enc
    import hex_scroll_pkg::*;
(
    input  glyph_t     glyph,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (glyph)
            G_X0, G_O: seg = 7'h40;
            G_X1:      seg = 7'h79;
            G_X2:      seg = 7'h24;
            G_X3:      seg = 7'h30;
            G_X4:      seg = 7'h19;
            G_X5:      seg = 7'h12;
            G_X6:      seg = 7'h02;
            G_X7:      seg = 7'h78;
            G_X8:      seg = 7'h00;
            G_X9:      seg = 7'h10;
            G_XA, G_A: seg = 7'h08;
            G_XB, G_B: seg = 7'h03;
            G_XC, G_C: seg = 7'h46;
            G_XD:      seg = 7'h21;
            G_XE, G_E: seg = 7'h06;
            G_XF:      seg = 7'h0E;
            G_H:       seg = 7'h09;
            G_L:       seg = 7'h47;
            G_P:       seg = 7'h0C;
            G_DASH:    seg = 7'h3F;
            G_BLANK:   seg = 7'h7F;
            default:   seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Scrolls the message across HEX5..HEX0 at one step per TICK_DIV cycles;
// a debounced KEY1 press toggles run/pause.
module hex_scroll_ctrl
    import hex_scroll_pkg::*;
#(
    parameter int TICK_DIV  = 12_500_000,
    parameter int DB_CYCLES = 500_000
) (
    input  logic       MAX10_CLK1_50,
    input  logic       RST_N,
    input  logic       KEY1,
    output logic [7:0] HEX0,
    output logic [7:0] HEX1,
    output logic [7:0] HEX2,
    output logic [7:0] HEX3,
    output logic [7:0] HEX4,
    output logic [7:0] HEX5,
    output logic [3:0] POS
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DB_CYCLES);

    logic clk, rst_n;
    assign clk   = MAX10_CLK1_50;
    assign rst_n = RST_N;

    logic          key_s1, key_s2, key_lvl, press;
    logic [DW-1:0] db_cnt;
    logic [PW-1:0] pre_cnt;
    logic          tick;
    state_t        state_q, state_d;
    logic [3:0]    pos_q, pos_d;
    glyph_t        glyph [6];
    logic [5:0][6:0] seg;
    logic [5:0][7:0] hex_q;

    // Counter only runs while the synchronised level disagrees with the
    // accepted one, so any return to the old level restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1  <= 1'b1;
            key_s2  <= 1'b1;
            key_lvl <= 1'b1;
            db_cnt  <= '0;
            press   <= 1'b0;
        end else begin
            key_s1 <= KEY1;
            key_s2 <= key_s1;
            press  <= 1'b0;
            if (key_s2 == key_lvl) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DB_CYCLES - 1)) begin
                db_cnt  <= '0;
                key_lvl <= key_s2;
                press   <= ~key_s2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign tick = (pre_cnt == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          pre_cnt <= '0;
        else if (state_q == PAUSE || tick)   pre_cnt <= '0;
        else                                 pre_cnt <= pre_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
        end
    end

    // press is checked before tick so a coincident press freezes POS
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        case (state_q)
            IDLE:  if (tick) begin
                       state_d = RUN;
                       pos_d   = '0;
                   end
            RUN:   if (press)     state_d = PAUSE;
                   else if (tick) pos_d   = pos_q + 4'd1;
            PAUSE: if (press)     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    for (genvar d = 0; d < 6; d++) begin : g_digit
        assign glyph[d] = MSG_DEFAULT[pos_q + 4'(5 - d)];
        seg7_glyph_enc u_enc (.glyph(glyph[d]), .seg(seg[d]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_q <= '1;
        end else begin
            for (int d = 0; d < 6; d++) begin
                if (state_q == IDLE) hex_q[d] <= 8'hFF;
                else                 hex_q[d] <= {!(d == 0 && state_q == PAUSE), seg[d]};
            end
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];
    assign POS  = pos_q;

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Bench for hex_scroll_ctrl: directed frame table, hand-timed pause/bounce/reset
// sequences, then random KEY1/reset traffic against a behavioural model.
module tb_hex_scroll_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int DB_CYCLES = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic key1 = 1'b1;
    logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [3:0] pos;
    logic [5:0][7:0] hex;

    assign hex = {hex5, hex4, hex3, hex2, hex1, hex0};

    always #5 clk = ~clk;

    hex_scroll_ctrl #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
        .MAX10_CLK1_50(clk), .RST_N(rst_n), .KEY1(key1),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2),
        .HEX3(hex3), .HEX4(hex4), .HEX5(hex5), .POS(pos)
    );

    int tests = 0;
    int fails = 0;

    // displayed byte (DP off) for each message index, from segment charts
    localparam logic [7:0] MSG_BYTES [16] = '{
        8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0, 8'hFF, 8'hC6, 8'h88,
        8'hFF, 8'hC7, 8'h88, 8'h83, 8'hFF, 8'hFF, 8'hFF, 8'hFF
    };

    typedef struct {
        int              cyc;
        logic [3:0]      pos;
        logic [5:0][7:0] hex;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_frame(input string name, input logic [5:0][7:0] e);
        for (int d = 0; d < 6; d++)
            chk($sformatf("%s HEX%0d", name, d), hex[d], e[d]);
    endtask

    task automatic chk_pos(input string name, input logic [3:0] e);
        chk(name, {4'h0, pos}, {4'h0, e});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        key1  = 1'b1;
        #1;
        chk_frame("reset", {6{8'hFF}});
        chk_pos("reset POS", 4'd0);
        step(2);
        chk_frame("held reset", {6{8'hFF}});
        rst_n = 1'b1;
    endtask

    // ---------------- behavioural reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_PAUSE} mstate_e;
    mstate_e         m_st;
    int              m_pos, m_ph;
    bit              m_lvl, m_press, m_d1, m_d2;
    bit              hist [$];
    logic [5:0][7:0] m_exp;

    function automatic logic [7:0] frame_byte(input mstate_e st, input int p, input int d);
        logic [7:0] b;
        if (st == M_IDLE) return 8'hFF;
        b = MSG_BYTES[(p + 5 - d) % 16];
        if (d == 0 && st == M_PAUSE) b[7] = 1'b0;
        return b;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_pos = 0; m_ph = 0;
        m_lvl = 1'b1; m_press = 1'b0; m_d1 = 1'b1; m_d2 = 1'b1;
        hist.delete();
        m_exp = {6{8'hFF}};
    endtask

    // One clock edge; k is the KEY1 level held during the cycle just ended.
    task automatic model_edge(input bit k);
        bit      tick, all_eq;
        mstate_e old;
        for (int d = 0; d < 6; d++) m_exp[d] = frame_byte(m_st, m_pos, d);
        old  = m_st;
        tick = (m_ph == TICK_DIV - 1);
        case (m_st)
            M_IDLE:  if (tick) begin m_st = M_RUN; m_pos = 0; end
            M_RUN:   if (m_press) m_st = M_PAUSE;
                     else if (tick) m_pos = (m_pos + 1) % 16;
            M_PAUSE: if (m_press) m_st = M_RUN;
            default: m_st = M_IDLE;
        endcase
        m_ph = (old == M_PAUSE) ? 0 : (m_ph + 1) % TICK_DIV;
        // level accepted once the last DB_CYCLES synchronised samples agree
        hist.push_back(m_d2);
        m_d2 = m_d1;
        m_d1 = k;
        if (hist.size() > DB_CYCLES) void'(hist.pop_front());
        m_press = 1'b0;
        if (hist.size() == DB_CYCLES) begin
            all_eq = 1'b1;
            for (int i = 1; i < DB_CYCLES; i++) if (hist[i] != hist[0]) all_eq = 1'b0;
            if (all_eq && hist[0] != m_lvl) begin
                m_lvl   = hist[0];
                m_press = !m_lvl;
            end
        end
    endtask

    initial begin
        int hold;

        tbl[0] = '{4,  4'd0,  {6{8'hFF}}};
        tbl[1] = '{1,  4'd0,  {8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0, 8'hFF}};
        tbl[2] = '{3,  4'd1,  {8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0, 8'hFF}};
        tbl[3] = '{1,  4'd1,  {8'h86, 8'hC7, 8'hC7, 8'hC0, 8'hFF, 8'hC6}};
        tbl[4] = '{4,  4'd2,  {8'hC7, 8'hC7, 8'hC0, 8'hFF, 8'hC6, 8'h88}};
        tbl[5] = '{36, 4'd11, {8'h83, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h89}};
        tbl[6] = '{12, 4'd14, {8'hFF, 8'hFF, 8'h89, 8'h86, 8'hC7, 8'hC7}};
        tbl[7] = '{4,  4'd15, {8'hFF, 8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0}};
        tbl[8] = '{4,  4'd0,  {8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0, 8'hFF}};

        #2;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].cyc);
            chk_pos($sformatf("vec%0d POS", i), tbl[i].pos);
            chk_frame($sformatf("vec%0d", i), tbl[i].hex);
        end

        // pause: KEY1 falls right after edge 69, state changes on edge 75
        key1 = 1'b0;
        step(5);  chk("pre-pause HEX0", hex0, 8'hC6);
        step(1);  chk("pause edge HEX0", hex0, 8'hC6);
        step(1);  chk("pause DP HEX0", hex0, 8'h46);
                  chk_pos("pause POS", 4'd1);
        step(1);  key1 = 1'b1;
        step(12); chk_pos("frozen POS", 4'd1);
                  chk("frozen HEX0", hex0, 8'h46);
                  chk("frozen HEX5", hex5, 8'h86);
        // resume: RUN on edge 95, next advance on edge 99
        key1 = 1'b0;
        step(6);  chk("resume edge HEX0", hex0, 8'h46);
        step(1);  chk("resumed HEX0", hex0, 8'hC6);
                  chk_pos("resumed POS", 4'd1);
        step(1);  key1 = 1'b1;
        step(1);  chk_pos("resume+3 POS", 4'd1);
        step(1);  chk_pos("resume+4 POS", 4'd2);

        // press accepted on the same edge as a tick
        do_reset();
        step(6);  key1 = 1'b0;
        step(6);  chk_pos("press+tick POS", 4'd1);
        step(1);  chk_pos("press+tick POS hold", 4'd1);
                  chk("press+tick HEX0", hex0, 8'h46);
        step(1);  key1 = 1'b1;
        step(8);  chk_pos("press+tick later POS", 4'd1);

        // bounce shorter than the debounce window
        do_reset();
        step(5);
        for (int i = 0; i < 20; i++) begin
            key1 = ((i / 2) % 2) == 1;
            step(1);
        end
        key1 = 1'b1;
        step(8);  chk_pos("bounce POS", 4'd7);
                  chk("bounce HEX0", hex0, 8'hFF);

        // reset while a press is being counted
        do_reset();
        step(6);  key1 = 1'b0;
        step(3);  rst_n = 1'b0;
        #1;
        chk_frame("mid-debounce reset", {6{8'hFF}});
        chk_pos("mid-debounce reset POS", 4'd0);
        key1 = 1'b1;
        step(2);  rst_n = 1'b1;
        step(20); chk_pos("after reset POS", 4'd4);
                  chk("after reset HEX0", hex0, 8'hFF);

        // random KEY1 activity and occasional resets against the model
        do_reset();
        model_reset();
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                key1 = ($urandom_range(0, 2) != 0);
                hold = $urandom_range(1, 9);
            end
            hold--;
            rst_n = ($urandom_range(0, 399) != 0);
            @(posedge clk);
            #1;
            if (!rst_n) model_reset();
            else        model_edge(key1);
            tests++;
            if (hex !== m_exp || pos !== 4'(m_pos)) begin
                fails++;
                $display("FAIL random c=%0d: got POS=%h HEX=%h, expected POS=%h HEX=%h",
                         c, pos, hex, 4'(m_pos), m_exp);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
